// File: rtl/reduction_seq_pkg.sv
// Shared types and width helpers for the reduction sequencer.
package reduction_seq_pkg;

    // Controller states: wait for a command, sum a burst, offer the result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    // Accumulator width that cannot overflow: one lane, times the lane count,
    // times the longest burst (2^len_width beats).
    function automatic int acc_width(input int width, input int num_mod, input int len_width);
        return width + $clog2(num_mod) + len_width;
    endfunction

endpackage

// File: rtl/reduction_sequencer_adder_tree.sv
// Combinational adder tree: sums NUM_MOD unsigned lanes of WIDTH bits.
// Each level halves the node count; the sum grows one bit per level.
module reduction_sequencer_adder_tree #(
    parameter int WIDTH   = 8,
    parameter int NUM_MOD = 32,
    parameter int LEVEL   = 5
) (
    input  logic [WIDTH*NUM_MOD-1:0] i_data,
    output logic [WIDTH+LEVEL-1:0]   o_sum
);

    localparam int SUM_W = WIDTH + LEVEL;

    // Level 0 holds the zero-extended lanes; level LEVEL node 0 is the total.
    logic [LEVEL:0][NUM_MOD-1:0][SUM_W-1:0] lvl;

    // Pairwise reduction, level by level; unused upper nodes stay zero.
    always_comb begin
        lvl = '0;
        for (int i = 0; i < NUM_MOD; i++) begin
            lvl[0][i] = SUM_W'(i_data[i*WIDTH +: WIDTH]);
        end
        for (int l = 1; l <= LEVEL; l++) begin
            for (int n = 0; n < (NUM_MOD >> l); n++) begin
                lvl[l][n] = lvl[l-1][2*n] + lvl[l-1][2*n+1];
            end
        end
    end

    assign o_sum = lvl[LEVEL][0];

endmodule

// File: rtl/reduction_sequencer.sv
// Two-requester reduction controller: round-robin command arbitration,
// burst accumulation of adder-tree sums, and a tagged scalar result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold I_Cmd_*/I_Data_* until accepted; the result is
// held stable on O_Res_* while O_Res_Valid is high until I_Res_Ready.
module reduction_sequencer
    import reduction_seq_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int NUM_MOD   = 32,
    parameter  int LEVEL     = 5,
    parameter  int LEN_WIDTH = 8,
    localparam int ACC_WIDTH = acc_width(WIDTH, NUM_MOD, LEN_WIDTH)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [1:0]                          I_Cmd_Valid,
    input  logic [1:0][LEN_WIDTH-1:0]           I_Cmd_Len,
    output logic [1:0]                          O_Cmd_Ready,
    input  logic [1:0]                          I_Data_Valid,
    input  logic [1:0][WIDTH*NUM_MOD-1:0]       I_Data,
    output logic [1:0]                          O_Data_Ready,
    output logic                                O_Res_Valid,
    output logic [ACC_WIDTH-1:0]                O_Res_Val,
    output logic                                O_Res_Id,
    input  logic                                I_Res_Ready,
    output logic                                O_Busy,
    output state_t                              O_Dbg_State
);

    localparam int SUM_W = WIDTH + LEVEL;

    state_t                 state_q, state_d;
    logic                   id_q, id_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ptr_q, ptr_d;   // requester favoured on a tie

    logic                   grant;
    logic                   cmd_fire;
    logic                   beat_fire;
    logic [WIDTH*NUM_MOD-1:0] mux_data;
    logic [SUM_W-1:0]       tree_sum;

    // Arbitration and ready generation from registered state plus valids.
    always_comb begin
        grant = 1'b0;
        unique case (I_Cmd_Valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ptr_q;
            default: grant = 1'b0;
        endcase
        O_Cmd_Ready = 2'b00;
        if (state_q == IDLE && |I_Cmd_Valid) begin
            O_Cmd_Ready[grant] = 1'b1;
        end
        O_Data_Ready = 2'b00;
        if (state_q == ACCUM) begin
            O_Data_Ready[id_q] = 1'b1;
        end
        cmd_fire  = (state_q == IDLE) && |I_Cmd_Valid;
        beat_fire = (state_q == ACCUM) && I_Data_Valid[id_q];
        mux_data  = I_Data[id_q];
    end

    reduction_sequencer_adder_tree #(
        .WIDTH   (WIDTH),
        .NUM_MOD (NUM_MOD),
        .LEVEL   (LEVEL)
    ) u_adder_tree (
        .i_data (mux_data),
        .o_sum  (tree_sum)
    );

    // Next-state logic for the FSM, counter, accumulator and pointer.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = ACCUM;
                    id_d    = grant;
                    cnt_d   = I_Cmd_Len[grant];
                    acc_d   = '0;
                end
            end
            ACCUM: begin
                if (beat_fire) begin
                    acc_d = acc_q + ACC_WIDTH'(tree_sum);
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == '0) begin
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                // Returning to IDLE first means no command is taken this cycle.
                if (I_Res_Ready) begin
                    state_d = IDLE;
                    ptr_d   = ~id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
        end
    end

    assign O_Res_Valid = (state_q == RESULT);
    assign O_Res_Val   = acc_q;
    assign O_Res_Id    = id_q;
    assign O_Busy      = (state_q != IDLE);
    assign O_Dbg_State = state_q;

endmodule

// File: tb/tb_reduction_sequencer.sv
// Directed and randomized bench for reduction_sequencer.
module tb_reduction_sequencer;
  import reduction_seq_pkg::*;

  localparam int WIDTH     = 8;
  localparam int NUM_MOD   = 32;
  localparam int LEVEL     = 5;
  localparam int LEN_WIDTH = 8;
  localparam int ACC_WIDTH = acc_width(WIDTH, NUM_MOD, LEN_WIDTH);
  localparam int VEC_W     = WIDTH * NUM_MOD;

  logic                          clock = 1'b0;
  logic                          reset;
  logic [1:0]                    I_Cmd_Valid;
  logic [1:0][LEN_WIDTH-1:0]     I_Cmd_Len;
  logic [1:0]                    O_Cmd_Ready;
  logic [1:0]                    I_Data_Valid;
  logic [1:0][VEC_W-1:0]         I_Data;
  logic [1:0]                    O_Data_Ready;
  logic                          O_Res_Valid;
  logic [ACC_WIDTH-1:0]          O_Res_Val;
  logic                          O_Res_Id;
  logic                          I_Res_Ready;
  logic                          O_Busy;
  state_t                        O_Dbg_State;

  reduction_sequencer #(
    .WIDTH     (WIDTH),
    .NUM_MOD   (NUM_MOD),
    .LEVEL     (LEVEL),
    .LEN_WIDTH (LEN_WIDTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .I_Cmd_Valid  (I_Cmd_Valid),
    .I_Cmd_Len    (I_Cmd_Len),
    .O_Cmd_Ready  (O_Cmd_Ready),
    .I_Data_Valid (I_Data_Valid),
    .I_Data       (I_Data),
    .O_Data_Ready (O_Data_Ready),
    .O_Res_Valid  (O_Res_Valid),
    .O_Res_Val    (O_Res_Val),
    .O_Res_Id     (O_Res_Id),
    .I_Res_Ready  (I_Res_Ready),
    .O_Busy       (O_Busy),
    .O_Dbg_State  (O_Dbg_State)
  );

  // Clock
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected results in issue order, with their owners.
  logic [ACC_WIDTH-1:0] exp_q[$];
  logic                 exp_id_q[$];
  // Reference arbitration: requester that wins a tie.
  logic                 fav;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build one beat from a lane pattern and return its lane sum.
  task automatic build_beat(input int pat, output logic [VEC_W-1:0] v, output int s);
    int lane;
    s = 0;
    v = '0;
    for (int i = 0; i < NUM_MOD; i++) begin
      case (pat)
        0:       lane = 255;
        1:       lane = i;
        2:       lane = 1;
        default: lane = int'($urandom_range(255));
      endcase
      v[i*WIDTH +: WIDTH] = WIDTH'(lane);
      s += lane;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    I_Cmd_Valid = 2'b00;
    I_Data_Valid = 2'b00;
    I_Res_Ready = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    fav = 1'b0;
  endtask

  // One command/burst/result transaction. Entered and left at a negedge.
  // gap_pct < 0 toggles data valid 1-0-1; abort_after >= 0 resets mid-burst.
  task automatic burst(input logic [1:0] req_v, input int len0, input int len1,
                       input int pat, input int gap_pct, input int stall,
                       input bit hold_cmd, input int abort_after,
                       output int cycles, output logic [ACC_WIDTH-1:0] res_seen);
    logic w;
    int len, got, budget, bs;
    bit dv;
    logic [VEC_W-1:0] v;
    logic [ACC_WIDTH-1:0] sum;
    cycles = 0;
    res_seen = '0;
    w = (req_v == 2'b11) ? fav : req_v[1];
    len = w ? len1 : len0;
    I_Cmd_Valid = req_v;
    I_Cmd_Len[0] = LEN_WIDTH'(len0);
    I_Cmd_Len[1] = LEN_WIDTH'(len1);
    #1;
    check("cmd_ready_grant", O_Cmd_Ready, 2'b01 << w);
    check("busy_idle", O_Busy, 0);
    cycles = 1;
    @(posedge clock);
    @(negedge clock);
    if (!hold_cmd) I_Cmd_Valid = 2'b00;
    sum = '0;
    got = 0;
    budget = 0;
    while (got <= len && budget < 2000) begin
      dv = (gap_pct < 0) ? (budget % 2 == 0) : (int'($urandom_range(99)) >= gap_pct);
      build_beat(pat, v, bs);
      I_Data[w] = v;
      I_Data[!w] = {8{$urandom()}};
      I_Data_Valid[w] = dv;
      I_Data_Valid[!w] = 1'($urandom_range(1));
      #1;
      check("data_ready_owner", O_Data_Ready, 2'b01 << w);
      check("busy_accum", O_Busy, 1);
      check("res_valid_accum", O_Res_Valid, 0);
      check("cmd_ready_accum", O_Cmd_Ready, 0);
      if (dv) begin
        sum = sum + ACC_WIDTH'(bs);
        got++;
      end
      budget++;
      cycles++;
      @(posedge clock);
      @(negedge clock);
      if (abort_after >= 0 && got == abort_after) begin
        reset = 1'b1;
        I_Data_Valid = 2'b00;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        fav = 1'b0;
        #1;
        check("abort_busy", O_Busy, 0);
        check("abort_state", O_Dbg_State, IDLE);
        check("abort_data_ready", O_Data_Ready, 0);
        check("abort_res_valid", O_Res_Valid, 0);
        return;
      end
    end
    check("beats_accepted", got, len + 1);
    I_Data_Valid = 2'b00;
    exp_q.push_back(sum);
    exp_id_q.push_back(w);
    for (int s = 0; s <= stall; s++) begin
      I_Res_Ready = (s == stall);
      I_Cmd_Valid = 2'b11;
      I_Cmd_Len[0] = LEN_WIDTH'($urandom_range(255));
      I_Cmd_Len[1] = LEN_WIDTH'($urandom_range(255));
      #1;
      check("res_valid", O_Res_Valid, 1);
      check("res_val", O_Res_Val, exp_q[0]);
      check("res_id", O_Res_Id, exp_id_q[0]);
      check("cmd_ready_result", O_Cmd_Ready, 0);
      res_seen = O_Res_Val;
      cycles++;
      @(posedge clock);
      @(negedge clock);
    end
    void'(exp_q.pop_front());
    void'(exp_id_q.pop_front());
    I_Res_Ready = 1'b0;
    I_Cmd_Valid = hold_cmd ? req_v : 2'b00;
    fav = ~w;
    #1;
    check("busy_after_result", O_Busy, 0);
    check("res_valid_after", O_Res_Valid, 0);
  endtask

  initial begin
    int cyc;
    logic [ACC_WIDTH-1:0] seen;
    logic [1:0] rv;

    I_Cmd_Len = '0;
    I_Data = '0;
    do_reset();

    // Reset release, idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      #1;
      check("rst_busy", O_Busy, 0);
      check("rst_cmd_ready", O_Cmd_Ready, 0);
      check("rst_data_ready", O_Data_Ready, 0);
      check("rst_res_valid", O_Res_Valid, 0);
      check("rst_res_val", O_Res_Val, 0);
      check("rst_res_id", O_Res_Id, 0);
      check("rst_state", O_Dbg_State, IDLE);
      @(negedge clock);
    end

    // Req 0, Len=3, all lanes 0xFF, back-to-back.
    burst(2'b01, 3, 0, 0, 0, 0, 1'b0, -1, cyc, seen);
    check("t2_value", seen, 32640);
    check("t2_cycles", cyc, 6);

    // Req 1, Len=0, lane i carries i.
    burst(2'b10, 0, 0, 1, 0, 0, 1'b0, -1, cyc, seen);
    check("t3_value", seen, 496);
    check("t3_cycles", cyc, 3);

    // Both requesters valid every cycle from reset, Len=1: grants alternate.
    do_reset();
    I_Cmd_Valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_grant", O_Cmd_Ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      burst(2'b11, 1, 1, 3, 0, 0, 1'b1, -1, cyc, seen);
      check("alt_cycles", cyc, 4);
    end
    I_Cmd_Valid = 2'b00;
    @(negedge clock);

    // Data valid toggled, consumer stalled 5 cycles.
    burst(2'b01, 3, 0, 3, -1, 5, 1'b0, -1, cyc, seen);
    check("t5_cycles", cyc, 1 + 7 + 6);

    // Reset mid-burst after 2 of 4 beats, then a clean reissue.
    burst(2'b01, 3, 0, 0, 0, 0, 1'b0, 2, cyc, seen);
    burst(2'b01, 0, 0, 2, 0, 0, 1'b0, -1, cyc, seen);
    check("t6_value", seen, 32);

    // Longest burst of maximal lanes: largest possible result.
    burst(2'b10, 0, 255, 0, 0, 0, 1'b0, -1, cyc, seen);
    check("max_value", seen, 2088960);
    check("max_cycles", cyc, 258);

    // Randomized transactions.
    for (int i = 0; i < 20; i++) begin
      rv = 2'($urandom_range(3, 1));
      burst(rv, int'($urandom_range(5)), int'($urandom_range(5)), 3, 30,
            int'($urandom_range(3)), 1'b0, -1, cyc, seen);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
